// File: rtl/dbus_lsu_pkg.sv
// Shared definitions for the data-bus load/store unit: RV32 funct3 access
// modes, FSM state encoding and the alignment legality rule.
package dbus_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned one; 011/110/111 never legal.
  function automatic logic access_legal(input logic [2:0] mode, input logic [1:0] lo);
    logic ok;
    case (mode)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~lo[0];
      F3_W:        ok = (lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_lsu_if.sv
// Bus-side signal bundle of the load/store unit with master (LSU) and
// slave (memory) views.
interface dbus_lsu_if #(
  parameter int ADDR_W = 30
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [3:0]        byte_en;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic              ack;

  modport master (output addr, re, we, byte_en, wd, input rd, ack);
  modport slave  (input addr, re, we, byte_en, wd, output rd, ack);
endinterface

// File: rtl/dbus_lane_align.sv
// Combinational lane steering: store byte enables and lane replication,
// plus load lane extraction with sign/zero extension.
module dbus_lane_align
  import dbus_lsu_pkg::*;
(
  input  logic [2:0]  st_mode,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  byte_en,
  output logic [31:0] wd_rep,
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rd_raw,
  output logic [31:0] rd_ext
);

  logic [31:0] rd_shift;

  always_comb begin
    byte_en = 4'b1111;
    wd_rep  = st_data;
    case (st_mode)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << st_lo;
        wd_rep  = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        byte_en = 4'b0011 << {st_lo[1], 1'b0};
        wd_rep  = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  assign rd_shift = rd_raw >> {ld_lo, 3'b000};

  always_comb begin
    rd_ext = rd_raw;
    case (ld_mode)
      F3_B:    rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      F3_BU:   rd_ext = {24'h000000, rd_shift[7:0]};
      F3_H:    rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      F3_HU:   rd_ext = {16'h0000, rd_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dbus_lsu.sv
// Single-outstanding data-bus load/store unit: accepts one CPU access,
// drives a registered bus request until ack or timeout, returns load data.
module dbus_lsu
  import dbus_lsu_pkg::*;
#(
  parameter int p_ADDR_W  = 30,
  parameter int p_TIMEOUT = 15
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_CpuRe,
  input  logic                i_CpuWe,
  input  logic [2:0]          i_BusMode,
  input  logic [31:0]         i_CpuAddr,
  input  logic [31:0]         i_CpuWd,
  output logic [31:0]         o_CpuRd,
  output logic                o_Stall,
  output logic                o_Misaligned,
  output logic                o_Fault,
  output logic [p_ADDR_W-1:0] o_DBusAddr,
  output logic                o_DBusRe,
  output logic                o_DBusWe,
  output logic [3:0]          o_DBusByteEn,
  output logic [31:0]         o_DBusWd,
  input  logic [31:0]         i_DBusRd,
  input  logic                i_DBusAck
);

  localparam logic [7:0] TIMEOUT_LIM = 8'(p_TIMEOUT);

  state_t      state, state_nxt;
  logic        req, legal, accept, timeout;
  logic [7:0]  wait_cnt;
  logic [2:0]  mode_q;
  logic [1:0]  addr_lo_q;
  logic        store_q;
  logic        fault_q;
  logic [31:0] rd_q;
  logic [3:0]  byte_en;
  logic [31:0] wd_rep, rd_ext;

  assign req     = i_CpuRe | i_CpuWe;
  assign legal   = access_legal(i_BusMode, i_CpuAddr[1:0]);
  assign timeout = ((wait_cnt + 8'd1) == TIMEOUT_LIM);

  dbus_lane_align u_align (
    .st_mode (i_BusMode),
    .st_lo   (i_CpuAddr[1:0]),
    .st_data (i_CpuWd),
    .byte_en (byte_en),
    .wd_rep  (wd_rep),
    .ld_mode (mode_q),
    .ld_lo   (addr_lo_q),
    .rd_raw  (rd_q),
    .rd_ext  (rd_ext)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    o_Stall      = 1'b0;
    o_Misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req && !i_Rst) begin
          if (legal) begin
            accept    = 1'b1;
            o_Stall   = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            o_Misaligned = 1'b1;
          end
        end
      end
      ST_REQ: begin
        o_Stall = 1'b1;
        if (i_DBusAck || timeout) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_DBusAddr   <= '0;
      o_DBusRe     <= 1'b0;
      o_DBusWe     <= 1'b0;
      o_DBusByteEn <= 4'b0000;
      o_DBusWd     <= 32'h0;
      wait_cnt     <= 8'd0;
      mode_q       <= 3'b000;
      addr_lo_q    <= 2'b00;
      store_q      <= 1'b0;
      fault_q      <= 1'b0;
      rd_q         <= 32'h0;
    end else if (accept) begin
      // A simultaneous load+store request is issued as a store.
      o_DBusAddr   <= i_CpuAddr[p_ADDR_W+1:2];
      o_DBusRe     <= i_CpuRe & ~i_CpuWe;
      o_DBusWe     <= i_CpuWe;
      o_DBusByteEn <= byte_en;
      o_DBusWd     <= wd_rep;
      wait_cnt     <= 8'd0;
      mode_q       <= i_BusMode;
      addr_lo_q    <= i_CpuAddr[1:0];
      store_q      <= i_CpuWe;
      fault_q      <= 1'b0;
      rd_q         <= 32'h0;
    end else if (state == ST_REQ) begin
      // Ack is tested first so it wins over a timeout in the same cycle.
      if (i_DBusAck) begin
        rd_q     <= i_DBusRd;
        o_DBusRe <= 1'b0;
        o_DBusWe <= 1'b0;
      end else if (timeout) begin
        fault_q  <= 1'b1;
        o_DBusRe <= 1'b0;
        o_DBusWe <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign o_CpuRd = (state == ST_DONE && !store_q && !fault_q) ? rd_ext : 32'h0;
  assign o_Fault = (state == ST_DONE) && fault_q;

endmodule

// File: doc/dbus_lsu.md
DBUS_LSU -- requirements
Module: dbus_lsu

Interface
REQ-001 Parameter p_ADDR_W, default 30, SHALL set the word-address width of o_DBusAddr.
REQ-002 Parameter p_TIMEOUT, default 15, range 1..255, SHALL set the maximum number of REQ cycles without ack before a fault.
REQ-003 The block SHALL use one clock, i_Clk, and a synchronous, active-high reset, i_Rst.
REQ-004 Ports SHALL be as follows, in this order:
- i_Clk, in, 1, clock.
- i_Rst, in, 1, synchronous active-high reset.
- i_CpuRe, in, 1, load request.
- i_CpuWe, in, 1, store request.
- i_BusMode, in, 3, RV32 funct3.
- i_CpuAddr, in, 32, byte address.
- i_CpuWd, in, 32, store data, LSB-aligned.
- o_CpuRd, out, 32, extended load data.
- o_Stall, out, 1, hold pipeline.
- o_Misaligned, out, 1, access rejected.
- o_Fault, out, 1, bus timeout.
- o_DBusAddr, out, p_ADDR_W, word address.
- o_DBusRe, out, 1, bus read strobe.
- o_DBusWe, out, 1, bus write strobe.
- o_DBusByteEn, out, 4, lane enables.
- o_DBusWd, out, 32, lane-replicated write data.
- i_DBusRd, in, 32, bus read data.
- i_DBusAck, in, 1, slave completion.

Function
REQ-005 The FSM SHALL have exactly the states IDLE, REQ and DONE.
REQ-006 An access is legal when the mode is 000 or 100 at any address, 001 or 101 with addr[0]=0, or 010 with addr[1:0]=00; modes 011, 110 and 111 are illegal.
REQ-007 In IDLE with (Re|We) and a legal access, the block SHALL assert o_Stall combinationally, register the address, mode, lanes and data, and enter REQ.
REQ-008 In IDLE with (Re|We) and an illegal access, the block SHALL assert o_Misaligned for that cycle, keep o_Stall=0, start no bus access and stay in IDLE.
REQ-009 When Re and We are both 1, the access SHALL be treated as a store only.
REQ-010 In REQ, o_DBusRe or o_DBusWe SHALL be 1 together with the registered address, byte enables and data, and o_Stall SHALL be 1.
REQ-011 In REQ with i_DBusAck=1, the block SHALL capture i_DBusRd and enter DONE.
REQ-012 In REQ, a wait counter SHALL increment each cycle without ack; when it reaches p_TIMEOUT, the block SHALL enter DONE with the fault flag set.
REQ-013 An ack arriving in the same cycle the counter reaches the limit SHALL win: no fault is raised.
REQ-014 In DONE, the block SHALL drive o_Stall=0, hold bus strobes at 0 and present o_CpuRd for exactly one cycle.
- o_CpuRd SHALL be 0 for stores and after a fault.
- o_Fault SHALL be 1 in DONE only after a timeout.
REQ-015 DONE SHALL ignore CPU inputs and go to IDLE unconditionally.
REQ-016 Minimum occupancy SHALL be 3 cycles (2 stall cycles); each cycle of ack delay adds one stall cycle.
REQ-017 Byte enables SHALL be:
- Byte modes: 0001<<addr[1:0].
- Half modes: 0011<<(2*addr[1]).
- Word mode: 1111.
REQ-018 Write data SHALL replicate byte data to all four lanes and halfword data to both halves; word data passes unchanged.
REQ-019 Load data SHALL be:
- LB/LH: the addressed lane, sign-extended.
- LBU/LHU: the addressed lane, zero-extended.
- LW: the full word.
REQ-020 i_DBusAck outside REQ SHALL be ignored.
REQ-021 o_DBusAddr SHALL equal registered addr[p_ADDR_W+1:2].

Reset
REQ-022 i_Rst SHALL force IDLE, clear the counter, capture registers and flags, and drive all outputs to 0 on the next edge, including mid-REQ, abandoning the transaction.
REQ-023 A request present in the first cycle after reset SHALL be accepted normally.

Structure
REQ-024 A shared package SHALL hold the funct3 mode constants (B, H, W, BU, HU) and the FSM state encoding.
REQ-025 Lane steering (byte enables, write replication, load extraction and extension) SHALL be a combinational sub-module, dbus_lane_align.
REQ-026 All bus-side outputs SHALL be registered.

Verification
REQ-027 LW at 0x100, ack in the first REQ cycle, rd 0xDEADBEEF: o_DBusAddr=0x40, ByteEn=1111, stall for 2 cycles, o_CpuRd=0xDEADBEEF in DONE.
REQ-028 SB 0x5A at 0x103, ack after 3 wait cycles: ByteEn=1000, Wd=0x5A5A5A5A, stall for 5 cycles.
REQ-029 LH at 0x102 with rd 0x80010000 -> o_CpuRd=0xFFFF8001; LHU with the same data -> 0x00008001.
REQ-030 LW at 0x101 -> o_Misaligned=1 for one cycle, no strobe, o_Stall=0; mode 011 gives the same response.
REQ-031 LW with no ack and p_TIMEOUT=15 -> DONE after 15 REQ cycles with o_Fault=1 and o_CpuRd=0; a repeat run with ack on cycle 15 gives no fault.
REQ-032 i_Rst asserted during the 2nd REQ cycle -> strobes 0 on the next edge, state IDLE, and a request on the following cycle completes normally.
